mem_stage: RTL and testbench



---
 rtl/riscv_cpu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 44 ++++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared types and constants for the CPU pipeline: opcodes, access sizes,
// memory-stage FSM states and the MEM->WB payload.
package riscv_cpu_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CSR_WIDTH  = 4;
    localparam int unsigned NUM_LANES  = 4;

    localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    // funct3 encodings of load/store widths
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] load_data;
        logic [CSR_WIDTH-1:0]  csr;
        logic                  misalign;
    } wb_payload_t;

    // Reset value and stall filler of the write-back register
    localparam wb_payload_t WB_BUBBLE = '{
        pc:         '0,
        instr:      INSTR_NOP,
        alu_result: '0,
        load_data:  '0,
        csr:        '0,
        misalign:   1'b0
    };

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper for the memory stage: byte enables, store-data lane
// replication and load-data extraction with sign/zero extension.
module lsu_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    // Enables past lane 3 fall off the 4-bit shift on purpose
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rdata_i >> {off_i, 3'b000};

    // funct3[2] selects the unsigned variants
    always_comb begin
        load_data_o = shifted;
        case (funct3_i[1:0])
            2'b00:   load_data_o = {{24{~funct3_i[2] & shifted[7]}},  shifted[7:0]};
            2'b01:   load_data_o = {{16{~funct3_i[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB: req/gnt/rvalid data port,
// stall generation and the registered WB payload.
// Optional MEM_MISALIGN_CHECK_EN: misaligned H/W accesses bypass memory and flag misalign_o.
module mem_stage
    import riscv_cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           instr_rdata_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic [CSR_WIDTH-1:0]  csr_i,
    output logic                  stall_o,
    output logic                  data_req_o,
    output logic                  data_we_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [31:0]           data_addr_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i,
    output logic [31:0]           pc_o,
    output logic [31:0]           instr_rdata_o,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic [CSR_WIDTH-1:0]  csr_o,
    output logic                  misalign_o
);

    mem_state_e  state_q, state_d;
    wb_payload_t wb_q, wb_d;

    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load, is_store, misalign, mem_op;
    logic        req_c, stall_c;
    logic [31:0] load_aligned;

    assign funct3   = instr_rdata_i[14:12];
    assign off      = alu_result_i[1:0];
    assign is_load  = (instr_rdata_i[6:0] == OPCODE_LOAD);
    assign is_store = (instr_rdata_i[6:0] == OPCODE_STORE);

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (is_load || is_store) begin
            if (funct3[1:0] == 2'b01) begin
                misalign = off[0];
            end else if (funct3[1:0] != 2'b00) begin
                misalign = (off != 2'b00);
            end
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = (is_load || is_store) && !misalign;

    lsu_align u_lsu_align (
        .funct3_i     (funct3),
        .off_i        (off),
        .store_data_i (data_b_i),
        .rdata_i      (data_rdata_i),
        .be_o         (data_be_o),
        .wdata_o      (data_wdata_o),
        .load_data_o  (load_aligned)
    );

    // Request/stall decode; stall releases in the cycle the response arrives
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    state_d = data_gnt_i ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (data_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_c = ~data_rvalid_i;
                if (data_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Keep the port quiet while reset is held, whatever EX presents
    assign data_req_o  = req_c & rst_ni;
    assign stall_o     = stall_c & rst_ni;
    assign data_we_o   = is_store & data_req_o;
    assign data_addr_o = {alu_result_i[31:2], 2'b00};

    always_comb begin
        wb_d = WB_BUBBLE;
        if (!stall_c) begin
            wb_d.pc         = pc_i;
            wb_d.instr      = instr_rdata_i;
            wb_d.alu_result = alu_result_i;
            wb_d.load_data  = (is_load && !misalign) ? load_aligned : '0;
            wb_d.csr        = csr_i;
            wb_d.misalign   = misalign;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            wb_q    <= WB_BUBBLE;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    assign pc_o          = wb_q.pc;
    assign instr_rdata_o = wb_q.instr;
    assign alu_result_o  = wb_q.alu_result;
    assign load_data_o   = wb_q.load_data;
    assign csr_o         = wb_q.csr;
    assign misalign_o    = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model plus directed vectors.
// Build with MEM_MISALIGN_CHECK_EN defined to exercise the misalignment bypass.
module tb_mem_stage;
    import riscv_cpu_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [31:0]           pc_i = '0;
    logic [31:0]           instr_rdata_i = INSTR_NOP;
    logic [DATA_WIDTH-1:0] alu_result_i = '0;
    logic [DATA_WIDTH-1:0] data_b_i = '0;
    logic [CSR_WIDTH-1:0]  csr_i = '0;
    logic                  stall_o, data_req_o, data_we_o;
    logic                  data_gnt_i = 1'b0;
    logic                  data_rvalid_i = 1'b0;
    logic [31:0]           data_addr_o;
    logic [3:0]            data_be_o;
    logic [31:0]           data_wdata_o;
    logic [31:0]           data_rdata_i = '0;
    logic [31:0]           pc_o, instr_rdata_o;
    logic [DATA_WIDTH-1:0] alu_result_o, load_data_o;
    logic [CSR_WIDTH-1:0]  csr_o;
    logic                  misalign_o;

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_i          (pc_i),
        .instr_rdata_i (instr_rdata_i),
        .alu_result_i  (alu_result_i),
        .data_b_i      (data_b_i),
        .csr_i         (csr_i),
        .stall_o       (stall_o),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_addr_o   (data_addr_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .pc_o          (pc_o),
        .instr_rdata_o (instr_rdata_o),
        .alu_result_o  (alu_result_o),
        .load_data_o   (load_data_o),
        .csr_o         (csr_o),
        .misalign_o    (misalign_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model expectations for the current cycle and the WB register
    logic        check_en = 1'b1;
    logic        in_reset = 1'b1;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    wb_payload_t exp_out = WB_BUBBLE;
    wb_payload_t cur_res = WB_BUBBLE;
    logic        cur_stall = 1'b0;

    // Observations of the most recent transaction
    int          n_stall, n_req;
    logic [3:0]  seen_be;
    logic        seen_we;
    logic [31:0] seen_wdata, seen_addr, seen_instr;

    localparam logic [31:0] I_ADD = 32'h0020_81B3;
    localparam logic [31:0] I_LB  = 32'h0000_8083;
    localparam logic [31:0] I_LH  = 32'h0000_9083;
    localparam logic [31:0] I_LW  = 32'h0000_A083;
    localparam logic [31:0] I_LHU = 32'h0000_D083;
    localparam logic [31:0] I_SB  = 32'h0020_8023;
    localparam logic [31:0] I_SH  = 32'h0020_9023;
    localparam logic [31:0] I_SW  = 32'h0020_A023;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Lane i is written when it lies inside [off, off+n) and below lane 4
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        int n, o;
        n  = nbytes(f3);
        o  = int'(off);
        be = '0;
        if (n == 4) return 4'hF;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        if (nbytes(f3) == 1) for (int i = 0; i < 4; i++) w[8*i +: 8] = d[7:0];
        if (nbytes(f3) == 2) for (int i = 0; i < 2; i++) w[16*i +: 16] = d[15:0];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] v;
        logic        sgn;
        int n, o;
        n = nbytes(f3);
        o = int'(off);
        v = '0;
        for (int i = 0; i < 4; i++) if (o + i < 4) v[8*i +: 8] = rd[8*(o+i) +: 8];
        if (n < 4) begin
            sgn = ~f3[2] & v[8*n-1];
            for (int b = 8*n; b < 32; b++) v[b] = sgn;
        end
        return v;
    endfunction

    function automatic logic m_misalign(input logic [2:0] f3, input logic [1:0] off);
`ifdef MEM_MISALIGN_CHECK_EN
        if (nbytes(f3) == 2) return off[0];
        if (nbytes(f3) == 4) return off != 2'b00;
        return 1'b0;
`else
        return 1'b0 & f3[0] & off[0];
`endif
    endfunction

    // Advance one clock; the WB register model captures last cycle's outcome
    task automatic step();
        @(posedge clk_i);
        exp_out = (in_reset || cur_stall) ? WB_BUBBLE : cur_res;
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                         input logic [31:0] b, input logic [CSR_WIDTH-1:0] csr);
        pc_i = pc;
        instr_rdata_i = instr;
        alu_result_i = alu;
        data_b_i = b;
        csr_i = csr;
    endtask

    task automatic observe();
        @(negedge clk_i);
        if (stall_o) n_stall++;
        if (data_req_o) begin
            n_req++;
            seen_be    = data_be_o;
            seen_we    = data_we_o;
            seen_wdata = data_wdata_o;
            seen_addr  = data_addr_o;
        end
        seen_instr = instr_rdata_o;
    endtask

    // One instruction: grant g cycles after presentation, response r cycles after grant.
    // rvalid is also driven high while the request is pending, where it must be ignored.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                         input logic [31:0] b, input logic [CSR_WIDTH-1:0] csr,
                         input int g, input int r, input logic [31:0] rdata);
        logic ld, st, mis, mem;
        logic [2:0] f3;
        logic [1:0] off;
        int last;
        f3   = instr[14:12];
        off  = alu[1:0];
        ld   = (instr[6:0] == OPCODE_LOAD);
        st   = (instr[6:0] == OPCODE_STORE);
        mis  = (ld || st) && m_misalign(f3, off);
        mem  = (ld || st) && !mis;
        last = mem ? g + r : 0;
        n_stall = 0;
        n_req   = 0;
        for (int c = 0; c <= last; c++) begin
            step();
            drive(pc, instr, alu, b, csr);
            data_gnt_i    = mem && (c == g);
            data_rvalid_i = mem && (c <= g || c == last);
            data_rdata_i  = (c == last) ? rdata : $urandom();
            exp_stall = mem && (c < last);
            exp_req   = mem && (c <= g);
            exp_we    = st;
            exp_addr  = {alu[31:2], 2'b00};
            exp_be    = m_be(f3, off);
            exp_wdata = m_wdata(f3, b);
            cur_stall = exp_stall;
            cur_res.pc         = pc;
            cur_res.instr      = instr;
            cur_res.alu_result = alu;
            cur_res.load_data  = (ld && !mis) ? m_load(f3, off, rdata) : '0;
            cur_res.csr        = csr;
            cur_res.misalign   = mis;
            observe();
        end
    endtask

    task automatic nop();
        issue(32'h0, INSTR_NOP, 32'h0, 32'h0, '0, 0, 1, 32'h0);
    endtask

    always @(negedge clk_i) begin
        if (check_en) begin
            chk("stall_o", 32'(stall_o), 32'(exp_stall));
            chk("data_req_o", 32'(data_req_o), 32'(exp_req));
            if (exp_req) begin
                chk("data_addr_o", data_addr_o, exp_addr);
                chk("data_be_o", 32'(data_be_o), 32'(exp_be));
                chk("data_we_o", 32'(data_we_o), 32'(exp_we));
                if (exp_we) chk("data_wdata_o", data_wdata_o, exp_wdata);
            end
            chk("pc_o", pc_o, exp_out.pc);
            chk("instr_rdata_o", instr_rdata_o, exp_out.instr);
            chk("alu_result_o", alu_result_o, exp_out.alu_result);
            chk("load_data_o", load_data_o, exp_out.load_data);
            chk("csr_o", 32'(csr_o), 32'(exp_out.csr));
            chk("misalign_o", 32'(misalign_o), 32'(exp_out.misalign));
        end
    end

    initial begin
        step();
        @(negedge clk_i);
        chk("rst_instr", instr_rdata_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req", 32'(data_req_o), 32'h0);
        step();
        rst_ni   = 1'b1;
        in_reset = 1'b0;
        @(negedge clk_i);

        // ALU op passes in one cycle without stalling
        issue(32'h1000, I_ADD, 32'h1234, 32'h0, 4'h3, 0, 1, 32'h0);
        chk("add_stall_cycles", 32'(n_stall), 32'd0);
        nop();
        chk("add_alu_result", alu_result_o, 32'h1234);

        // SW: occupies 2 cycles, stall high only in the request cycle
        issue(32'h1004, I_SW, 32'h100, 32'hDEAD_BEEF, 4'h1, 0, 1, 32'h5555_AAAA);
        chk("sw_be", 32'(seen_be), 32'hF);
        chk("sw_we", 32'(seen_we), 32'h1);
        chk("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", seen_addr, 32'h100);
        chk("sw_stall_cycles", 32'(n_stall), 32'd1);
        nop();
        chk("sw_load_data", load_data_o, 32'h0);

        // LB with grant delayed 3 cycles
        issue(32'h1008, I_LB, 32'h103, 32'h0, 4'h2, 3, 2, 32'h80FF_FFFF);
        chk("lb_req_cycles", 32'(n_req), 32'd4);
        chk("lb_be", 32'(seen_be), 32'b1000);
        chk("lb_bubble", seen_instr, 32'h0000_0013);
        nop();
        chk("lb_load_data", load_data_o, 32'hFFFF_FF80);

        issue(32'h100C, I_LHU, 32'h102, 32'h0, 4'h0, 1, 1, 32'hBEEF_0000);
        chk("lhu_be", 32'(seen_be), 32'b1100);
        nop();
        chk("lhu_load_data", load_data_o, 32'h0000_BEEF);

        // Further patterns checked only through the model
        issue(32'h1010, I_LH, 32'h100, 32'h0, 4'h7, 0, 3, 32'h1234_8001);
        issue(32'h1014, I_SB, 32'h105, 32'h0000_00A5, 4'h4, 2, 1, 32'h0);
        issue(32'h1018, I_LB, 32'h201, 32'h0, 4'h0, 0, 1, 32'h0000_7F00);

        // Misaligned word load
        issue(32'h101C, I_LW, 32'h101, 32'h0, 4'h9, 0, 1, 32'h1122_3344);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("lw_mis_req_cycles", 32'(n_req), 32'd0);
        nop();
        chk("lw_mis_flag", 32'(misalign_o), 32'h1);
        chk("lw_mis_load_data", load_data_o, 32'h0);
`else
        chk("lw_mis_be", 32'(seen_be), 32'hF);
        chk("lw_mis_req_cycles", 32'(n_req), 32'd1);
        nop();
        chk("lw_mis_flag", 32'(misalign_o), 32'h0);
        chk("lw_mis_load_data", load_data_o, 32'h0011_2233);
`endif
        // Halfword store crossing lane 3
        issue(32'h1020, I_SH, 32'h103, 32'h0000_1234, 4'h0, 0, 2, 32'h0);
        nop();

        // Reset while waiting for the response; the late rvalid must be ignored
        step();
        drive(32'h300, I_LW, 32'h200, 32'h0, 4'h5);
        data_gnt_i = 1'b1;
        data_rvalid_i = 1'b0;
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = 32'h200;
        exp_be    = 4'hF;
        cur_stall = 1'b1;
        @(negedge clk_i);
        step();
        data_gnt_i = 1'b0;
        exp_req = 1'b0;
        @(negedge clk_i);
        step();
        rst_ni   = 1'b0;
        in_reset = 1'b1;
        drive(32'h0, INSTR_NOP, 32'h0, 32'h0, '0);
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_out   = WB_BUBBLE;
        cur_stall = 1'b0;
        cur_res   = WB_BUBBLE;
        @(negedge clk_i);
        step();
        @(negedge clk_i);
        step();
        rst_ni   = 1'b1;
        in_reset = 1'b0;
        @(negedge clk_i);
        step();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk_i);
        chk("rst_late_rvalid_stall", 32'(stall_o), 32'h0);
        step();
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_instr", instr_rdata_o, 32'h0000_0013);
        chk("rst_mid_load_data", load_data_o, 32'h0);

        // Pipeline resumes normally after the aborted access
        issue(32'h1024, I_LW, 32'h200, 32'h0, 4'h6, 1, 1, 32'h0BAD_F00D);
        chk("post_rst_req_cycles", 32'(n_req), 32'd2);
        nop();
        chk("post_rst_load_data", load_data_o, 32'h0BAD_F00D);
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
